// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Minimum width of an index/counter able to address n values (never below 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and FIFO write port shared by the arbiter.
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned nreq  = 4,
   parameter int unsigned width = 16
);

   logic [nreq-1:0]       req;
   logic [nreq*width-1:0] req_data;
   logic                  fifo_full;
   logic [nreq-1:0]       gnt;
   logic                  fifo_wr_en;
   logic [width-1:0]      fifo_din;
   logic                  busy;
   logic [clog2(nreq)-1:0] owner;

   modport master (
      output req, req_data, fifo_full,
      input  gnt, fifo_wr_en, fifo_din, busy, owner
   );

   modport slave (
      input  req, req_data, fifo_full,
      output gnt, fifo_wr_en, fifo_din, busy, owner
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority pick: first set request after index last, wrapping, last itself lowest.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned nreq = 4
) (
   input  logic [nreq-1:0]        req,
   input  logic [clog2(nreq)-1:0] last,
   output logic                   found,
   output logic [clog2(nreq)-1:0] winner
);

   localparam int unsigned iw = clog2(nreq);

   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned k = 1; k <= nreq; k++) begin
         for (int unsigned i = 0; i < nreq; i++) begin
            if (!found && req[i] && ((32'(last) + k) % nreq) == i) begin
               found  = 1'b1;
               winner = iw'(i);
            end
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among nreq producers, bursts capped at burst words.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned nreq  = 4,
   parameter int unsigned width = 16,
   parameter int unsigned burst = 4
) (
   input logic           clk,
   input logic           rst,
   fifo_wr_arbiter_if.slave bus
);

   localparam int unsigned iw = clog2(nreq);
   localparam int unsigned cw = clog2(burst + 1);

   state_t          state;
   logic [iw-1:0]   owner_q;
   logic [iw-1:0]   last_q;
   logic [cw-1:0]   burst_cnt;
   logic [iw-1:0]   base;
   logic            own_req;
   logic [width-1:0] own_data;
   logic            accept;
   logic            rel;
   logic            found;
   logic [iw-1:0]   winner;

   always_comb begin
      own_req  = 1'b0;
      own_data = '0;
      for (int unsigned i = 0; i < nreq; i++) begin
         if (owner_q == iw'(i)) begin
            own_req  = bus.req[i];
            own_data = bus.req_data[i*width +: width];
         end
      end
   end

   assign accept = (state == ST_BUSY) && own_req && !bus.fifo_full;
   assign rel    = (state == ST_BUSY) &&
                   ((accept && burst_cnt == cw'(burst - 1)) || !own_req);

   // One picker serves both paths: IDLE scans after last, a release scans after the owner.
   assign base = (state == ST_BUSY) ? owner_q : last_q;

   rr_pick #(.nreq(nreq)) u_pick (
      .req    (bus.req),
      .last   (base),
      .found  (found),
      .winner (winner)
   );

   always_comb begin
      bus.gnt = '0;
      for (int unsigned i = 0; i < nreq; i++) begin
         bus.gnt[i] = accept && (owner_q == iw'(i));
      end
   end

   assign bus.fifo_wr_en = accept;
   assign bus.fifo_din   = accept ? own_data : '0;
   assign bus.busy       = (state == ST_BUSY);
   assign bus.owner      = owner_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner_q   <= '0;
         last_q    <= iw'(nreq - 1);
         burst_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  owner_q   <= winner;
                  burst_cnt <= '0;
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (rel) begin
                  last_q <= owner_q;
                  if (found) begin
                     owner_q   <= winner;
                     burst_cnt <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (accept) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a cycle-level reference of the arbitration rules.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;
   localparam int BURST = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.nreq(NREQ), .width(WIDTH)) bus ();

   fifo_wr_arbiter #(.nreq(NREQ), .width(WIDTH), .burst(BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          cyc;
      int          owner;
      logic [15:0] data;
   } wr_t;

   wr_t expq[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;
   int exp_busy  = 0;
   int exp_owner = 0;

   // reference model state
   int m_busy, m_owner, m_last, m_cnt;

   // producers
   bit          rq[NREQ];
   logic [15:0] dat[NREQ];
   int          pend[NREQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int base);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (base + k) % NREQ;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_cnt   = 0;
      for (int i = 0; i < NREQ; i++) begin
         rq[i]   = 1'b0;
         pend[i] = 0;
         dat[i]  = '0;
      end
   endtask

   // one clock cycle: drive inputs, predict, advance at the edge
   task automatic cycle(input int raise, input int drop, input int full_pct);
      logic [NREQ-1:0]       rv;
      logic [NREQ*WIDTH-1:0] dv;
      bit full, acc, rel;
      int w, o, n_busy, n_owner, n_last, n_cnt;
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i] && drop > 0 && $urandom_range(99) < drop) begin
            rq[i] = 1'b0;
         end else if (!rq[i] && pend[i] > 0 && $urandom_range(99) < raise) begin
            rq[i]  = 1'b1;
            dat[i] = {4'(i), 12'($urandom)};
         end
         rv[i] = rq[i];
         dv[i*WIDTH +: WIDTH] = dat[i];
      end
      full = ($urandom_range(99) < full_pct);
      bus.req       = rv;
      bus.req_data  = dv;
      bus.fifo_full = full;
      exp_busy  = m_busy;
      exp_owner = m_owner;

      o   = m_owner;
      acc = (m_busy != 0) && rv[o] && !full;
      if (acc) expq.push_back('{cyc, o, dat[o]});

      n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
      if (m_busy == 0) begin
         w = pick(rv, m_last);
         if (w >= 0) begin
            n_busy = 1; n_owner = w; n_cnt = 0;
         end
      end else begin
         rel = (acc && m_cnt == BURST - 1) || !rv[o];
         if (rel) begin
            n_last = o;
            w = pick(rv, o);
            if (w >= 0) begin
               n_owner = w; n_cnt = 0;
            end else begin
               n_busy = 0;
            end
         end else if (acc) begin
            n_cnt = m_cnt + 1;
         end
      end

      @(posedge clk);
      #1;
      cyc++;
      m_busy = n_busy; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
      if (acc) begin
         pend[o]--;
         rq[o] = 1'b0;
      end
   endtask

   task automatic phase(input logic [NREQ-1:0] mask, input int words, input int raise,
                        input int drop, input int full_pct, input int ncyc);
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = mask[i] ? words : 0;
         if (!mask[i]) rq[i] = 1'b0;
      end
      for (int c = 0; c < ncyc; c++) cycle(raise, drop, full_pct);
   endtask

   // asynchronous reset while a burst is in flight
   task automatic reset_mid();
      check("pre_reset_busy", 32'(m_busy), 32'd1);
      rst    = 1'b1;
      chk_en = 1'b0;
      #1;
      check("rst_async_gnt", 32'(bus.gnt), 32'd0);
      check("rst_async_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      check("rst_async_din", 32'(bus.fifo_din), 32'd0);
      check("rst_async_busy", 32'(bus.busy), 32'd0);
      model_reset();
      bus.req = '0;
      expq.delete();
      @(posedge clk);
      #1;
      cyc++;
      rst    = 1'b0;
      chk_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: got no write expected owner %0d data %0h (cycle %0d)",
                     expq[0].owner, expq[0].data, expq[0].cyc);
            void'(expq.pop_front());
         end
         check("busy", 32'(bus.busy), 32'(exp_busy));
         if (exp_busy != 0) check("owner", 32'(bus.owner), 32'(exp_owner));
         check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
         check("wr_en_vs_gnt", 32'(bus.fifo_wr_en), 32'(|bus.gnt));
         check("no_write_when_full", 32'(bus.fifo_wr_en && bus.fifo_full), 32'd0);
         if (bus.fifo_wr_en) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got gnt %0h data %0h expected no write (cycle %0d)",
                        bus.gnt, bus.fifo_din, cyc);
            end else begin
               wr_t e;
               e = expq.pop_front();
               check("write_cycle", 32'(cyc), 32'(e.cyc));
               check("write_din", 32'(bus.fifo_din), 32'(e.data));
               check("write_gnt", 32'(bus.gnt), 32'd1 << e.owner);
            end
         end else begin
            check("idle_din", 32'(bus.fifo_din), 32'd0);
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.req       = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_owner", 32'(bus.owner), 32'd0);
      check("reset_gnt", 32'(bus.gnt), 32'd0);
      check("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;

      phase(4'b0001, 3,   100, 0, 0,  8);   // three words, then idle
      phase(4'b0101, 100, 100, 0, 0,  20);  // alternating bursts of 4
      phase(4'b1111, 100, 100, 0, 0,  34);  // full rotation
      phase(4'b1111, 100, 100, 0, 40, 60);  // stalls from fifo_full
      phase(4'b0000, 0,   100, 0, 0,  5);
      phase(4'b0001, 10,  100, 0, 0,  15);  // 4,4,2 back to back
      for (int p = 0; p < 6; p++)
         phase(4'($urandom_range(1, 15)), $urandom_range(1, 8), 70, 10, 25, 80);
      phase(4'b0000, 0,   100, 0, 0,  5);
      phase(4'b0100, 20,  100, 0, 0,  6);
      reset_mid();
      phase(4'b1100, 20,  100, 0, 0,  12);  // owner 2 first after reset
      phase(4'b0000, 0,   100, 0, 0,  4);

      @(negedge clk);
      #1;
      check("queue_drained", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
